// File: rtl/ram_port_arbiter.sv
// -----------------------------------------------------------------------------
// ram_port_arbiter
//
// Round-robin arbiter that shares one req/gnt/rvalid memory port between
// NUM_MASTERS requesters (core LSU, debug, DMA). Each cycle, the first requesting
// master is chosen as the winner. The search starts at rr_ptr. The winner's
// request is forwarded to the slave port. Every accepted request pushes the
// winner's index into an ID FIFO. The slave answers in order, so each
// response pops the FIFO head and is steered back to the issuing master.
// This works with a fixed 1-cycle RAM and with slower slaves.
//
// Ports:
//   clk_i, rst_ni        clock, asynchronous active-low reset
//   m_req_i/m_we_i       per-master request / write enable
//   m_be_i               byte enables, master k at [4k+:4]
//   m_addr_i/m_wdata_i   address / write data, master k at [32k+:32]
//   m_gnt_o              one-hot grant (winner only, on slave handshake)
//   m_rvalid_o           one-hot response valid (FIFO head on s_rvalid_i)
//   m_rdata_o            shared read data, qualified by m_rvalid_o
//   s_req_o/s_gnt_i      slave request / grant (grant may depend on s_req_o)
//   s_we_o/s_be_o        forwarded write enable / byte enables
//   s_addr_o/s_wdata_o   forwarded address / write data
//   s_rvalid_i/s_rdata_i slave response valid / read data
//   outstanding_o        ID FIFO occupancy (granted, not yet answered)
//   resp_err_o           sticky: a response arrived with nothing outstanding
// -----------------------------------------------------------------------------
module ram_port_arbiter #(
  parameter int NUM_MASTERS     = 3,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic                                 clk_i,
  input  logic                                 rst_ni,
  input  logic [NUM_MASTERS-1:0]               m_req_i,
  input  logic [NUM_MASTERS-1:0]               m_we_i,
  input  logic [4*NUM_MASTERS-1:0]             m_be_i,
  input  logic [32*NUM_MASTERS-1:0]            m_addr_i,
  input  logic [32*NUM_MASTERS-1:0]            m_wdata_i,
  output logic [NUM_MASTERS-1:0]               m_gnt_o,
  output logic [NUM_MASTERS-1:0]               m_rvalid_o,
  output logic [31:0]                          m_rdata_o,
  output logic                                 s_req_o,
  input  logic                                 s_gnt_i,
  output logic                                 s_we_o,
  output logic [3:0]                           s_be_o,
  output logic [31:0]                          s_addr_o,
  output logic [31:0]                          s_wdata_o,
  input  logic                                 s_rvalid_i,
  input  logic [31:0]                          s_rdata_i,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding_o,
  output logic                                 resp_err_o
);

  localparam int ID_W  = $clog2(NUM_MASTERS);
  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

  // (base + off) mod NUM_MASTERS. off is at most NUM_MASTERS-1, so a single
  // conditional subtract is enough.
  function automatic logic [ID_W-1:0] wrap_id(input logic [ID_W-1:0] base,
                                              input int               off);
    int s;
    s = int'(base) + off;
    if (s >= NUM_MASTERS) s = s - NUM_MASTERS;
    return ID_W'(s);
  endfunction

  // FIFO pointer increment modulo MAX_OUTSTANDING (depth need not be 2^n)
  function automatic logic [PTR_W-1:0] wrap_ptr(input logic [PTR_W-1:0] p);
    if (int'(p) == MAX_OUTSTANDING - 1) return '0;
    return p + 1'b1;
  endfunction

  logic [ID_W-1:0]  rr_ptr;
  logic [ID_W-1:0]  win;
  logic             found;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic [ID_W-1:0]  id_fifo [MAX_OUTSTANDING];
  logic [ID_W-1:0]  head;
  logic             full;
  logic             empty;
  logic             hs;
  logic             pop;
  logic             resp_err;

  // Rotating-priority search. When nobody requests, win stays at rr_ptr.
  // The forwarded fields are then don't-care and come from that master.
  always_comb begin
    win   = rr_ptr;
    found = 1'b0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (!found && m_req_i[wrap_id(rr_ptr, i)]) begin
        win   = wrap_id(rr_ptr, i);
        found = 1'b1;
      end
    end
  end

  // full comes from the registered count only. A response that frees a slot
  // this cycle does not re-open the request path until the next cycle, so
  // there is no rvalid -> req combinational path.
  assign full  = (count == CNT_W'(MAX_OUTSTANDING));
  assign empty = (count == '0);

  assign s_req_o   = (|m_req_i) & ~full;
  assign s_we_o    = m_we_i[win];
  assign s_be_o    = m_be_i[int'(win)*4 +: 4];
  assign s_addr_o  = m_addr_i[int'(win)*32 +: 32];
  assign s_wdata_o = m_wdata_i[int'(win)*32 +: 32];

  assign hs   = s_req_o & s_gnt_i;
  assign pop  = s_rvalid_i & ~empty;
  assign head = id_fifo[rd_ptr];

  always_comb begin
    m_gnt_o = '0;
    if (hs) m_gnt_o[win] = 1'b1;
  end

  // An orphan response (FIFO empty) is routed to no master.
  always_comb begin
    m_rvalid_o = '0;
    if (pop) m_rvalid_o[head] = 1'b1;
  end

  assign m_rdata_o     = s_rdata_i;
  assign outstanding_o = count;
  assign resp_err_o    = resp_err;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_ptr   <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      resp_err <= 1'b0;
    end else begin
      if (hs) begin
        rr_ptr <= wrap_id(win, 1);
        wr_ptr <= wrap_ptr(wr_ptr);
      end
      if (pop) rd_ptr <= wrap_ptr(rd_ptr);
      case ({hs, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (s_rvalid_i && empty) resp_err <= 1'b1;
    end
  end

  // ID storage needs no reset. Entries are only read behind a valid count,
  // and reset discards the pointers and count.
  always_ff @(posedge clk_i) begin
    if (hs) id_fifo[wr_ptr] <= win;
  end

endmodule

// File: tb/tb_ram_port_arbiter.sv
module tb_ram_port_arbiter;
  localparam int N  = 3;
  localparam int MO = 2;
  localparam logic [31:0] KEY = 32'h5A5A_0F0F;

  logic            clk_i = 1'b0;
  logic            rst_ni;
  logic [N-1:0]    m_req_i;
  logic [N-1:0]    m_we_i;
  logic [4*N-1:0]  m_be_i;
  logic [32*N-1:0] m_addr_i;
  logic [32*N-1:0] m_wdata_i;
  logic [N-1:0]    m_gnt_o;
  logic [N-1:0]    m_rvalid_o;
  logic [31:0]     m_rdata_o;
  logic            s_req_o;
  logic            s_gnt_i;
  logic            s_we_o;
  logic [3:0]      s_be_o;
  logic [31:0]     s_addr_o;
  logic [31:0]     s_wdata_o;
  logic            s_rvalid_i;
  logic [31:0]     s_rdata_i;
  logic [1:0]      outstanding_o;
  logic            resp_err_o;

  // Slave model: a 1-cycle RAM that returns addr^KEY, or manual responses
  logic        ram_mode = 1'b0;
  logic        ram_rv   = 1'b0;
  logic [31:0] ram_rd   = '0;
  logic        man_rv   = 1'b0;
  logic [31:0] man_rd   = '0;

  typedef struct { int id; logic [31:0] data; } exp_t;
  exp_t q[$];

  int checks = 0;
  int errors = 0;

  always #5 clk_i = ~clk_i;

  assign s_rvalid_i = ram_mode ? ram_rv : man_rv;
  assign s_rdata_i  = ram_mode ? ram_rd : man_rd;

  always @(posedge clk_i) begin
    ram_rv <= s_req_o & s_gnt_i;
    ram_rd <= s_addr_o ^ KEY;
  end

  ram_port_arbiter #(.NUM_MASTERS(N), .MAX_OUTSTANDING(MO)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .m_req_i(m_req_i), .m_we_i(m_we_i), .m_be_i(m_be_i),
    .m_addr_i(m_addr_i), .m_wdata_i(m_wdata_i),
    .m_gnt_o(m_gnt_o), .m_rvalid_o(m_rvalid_o), .m_rdata_o(m_rdata_o),
    .s_req_o(s_req_o), .s_gnt_i(s_gnt_i), .s_we_o(s_we_o), .s_be_o(s_be_o),
    .s_addr_o(s_addr_o), .s_wdata_o(s_wdata_o),
    .s_rvalid_i(s_rvalid_i), .s_rdata_i(s_rdata_i),
    .outstanding_o(outstanding_o), .resp_err_o(resp_err_o)
  );

  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_reset();
    rst_ni = 1'b0; m_req_i = '0; m_we_i = '0; m_be_i = '0;
    m_addr_i = '0; m_wdata_i = '0; s_gnt_i = 1'b0;
    ram_mode = 1'b0; man_rv = 1'b0;
    @(negedge clk_i);
    checks++;
    if (m_gnt_o !== '0 || m_rvalid_o !== '0 || s_req_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs gnt=%b rvalid=%b s_req=%b expected 000 000 0", m_gnt_o, m_rvalid_o, s_req_o);
    end
    checks++;
    if (outstanding_o !== 2'd0 || resp_err_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_state outstanding=%0d resp_err=%b expected 0 0", outstanding_o, resp_err_o);
    end
    cyc();
    rst_ni = 1'b1;
  endtask

  task automatic test_round_robin();
    int   exp_ids [4];
    exp_t e;
    exp_ids = '{0, 1, 2, 0};
    ram_mode = 1'b1; s_gnt_i = 1'b1; m_we_i = '0; m_be_i = '1;
    for (int k = 0; k < N; k++) m_addr_i[32*k +: 32] = 32'h100 * (k + 1);
    m_req_i = '1;
    for (int g = 0; g < 5; g++) begin
      @(negedge clk_i);
      checks++;
      if (q.size() > 0) begin
        e = q.pop_front();
        if (m_rvalid_o !== N'(1 << e.id) || m_rdata_o !== e.data) begin
          errors++;
          $display("FAIL rr_resp%0d rvalid=%b rdata=%h expected rvalid=%b rdata=%h", g, m_rvalid_o, m_rdata_o, N'(1 << e.id), e.data);
        end
      end else if (m_rvalid_o !== '0) begin
        errors++;
        $display("FAIL rr_resp%0d rvalid=%b expected 000", g, m_rvalid_o);
      end
      checks++;
      if (g < 4) begin
        if (m_gnt_o !== N'(1 << exp_ids[g])) begin
          errors++;
          $display("FAIL rr_gnt%0d gnt=%b expected %b", g, m_gnt_o, N'(1 << exp_ids[g]));
        end
        e.id = exp_ids[g]; e.data = (32'h100 * (exp_ids[g] + 1)) ^ KEY;
        q.push_back(e);
      end else if (m_gnt_o !== '0 || s_req_o !== 1'b0) begin
        errors++;
        $display("FAIL rr_idle gnt=%b s_req=%b expected 000 0", m_gnt_o, s_req_o);
      end
      cyc();
      if (g == 3) m_req_i = '0;
    end
    @(negedge clk_i);
    checks++;
    if (outstanding_o !== 2'd0) begin
      errors++;
      $display("FAIL rr_drained outstanding=%0d expected 0", outstanding_o);
    end
    cyc();
  endtask

  task automatic test_backpressure();
    exp_t e;
    ram_mode = 1'b0; man_rv = 1'b0; s_gnt_i = 1'b1; m_req_i = '1;
    // pointer is at m1 after the previous sequence
    for (int g = 1; g <= 2; g++) begin
      @(negedge clk_i);
      checks++;
      if (m_gnt_o !== N'(1 << g)) begin
        errors++;
        $display("FAIL bp_gnt%0d gnt=%b expected %b", g, m_gnt_o, N'(1 << g));
      end
      e.id = g; e.data = '0;
      q.push_back(e);
      cyc();
    end
    @(negedge clk_i);
    checks++;
    if (s_req_o !== 1'b0 || m_gnt_o !== '0 || outstanding_o !== 2'd2) begin
      errors++;
      $display("FAIL bp_full s_req=%b gnt=%b outstanding=%0d expected 0 000 2", s_req_o, m_gnt_o, outstanding_o);
    end
    cyc();
    man_rv = 1'b1; man_rd = 32'hCAFE_0001;
    @(negedge clk_i);
    e = q.pop_front();
    checks++;
    if (m_rvalid_o !== N'(1 << e.id) || m_rdata_o !== 32'hCAFE_0001 || s_req_o !== 1'b0) begin
      errors++;
      $display("FAIL bp_first_resp rvalid=%b rdata=%h s_req=%b expected %b cafe0001 0", m_rvalid_o, m_rdata_o, s_req_o, N'(1 << e.id));
    end
    cyc();
    man_rv = 1'b0;
    @(negedge clk_i);
    checks++;
    if (s_req_o !== 1'b1 || m_gnt_o !== 3'b001 || outstanding_o !== 2'd1) begin
      errors++;
      $display("FAIL bp_reissue s_req=%b gnt=%b outstanding=%0d expected 1 001 1", s_req_o, m_gnt_o, outstanding_o);
    end
    e.id = 0; e.data = '0;
    q.push_back(e);
    cyc();
    m_req_i = '0;
    for (int r = 0; r < 2; r++) begin
      man_rv = 1'b1; man_rd = 32'hCAFE_0002 + r;
      @(negedge clk_i);
      e = q.pop_front();
      checks++;
      if (m_rvalid_o !== N'(1 << e.id) || m_rdata_o !== 32'hCAFE_0002 + r) begin
        errors++;
        $display("FAIL bp_drain%0d rvalid=%b rdata=%h expected %b %h", r, m_rvalid_o, m_rdata_o, N'(1 << e.id), 32'hCAFE_0002 + r);
      end
      cyc();
    end
    man_rv = 1'b0;
    @(negedge clk_i);
    checks++;
    if (outstanding_o !== 2'd0) begin
      errors++;
      $display("FAIL bp_empty outstanding=%0d expected 0", outstanding_o);
    end
    cyc();
  endtask

  task automatic test_single_write();
    exp_t e;
    ram_mode = 1'b1; s_gnt_i = 1'b1;
    m_req_i = 3'b010; m_we_i = 3'b010;
    m_be_i = {4'hF, 4'b0011, 4'hF};
    m_addr_i[32 +: 32] = 32'h0000_0010;
    m_wdata_i = {32'h1111_2222, 32'hA5A5_1234, 32'h3333_4444};
    @(negedge clk_i);
    checks++;
    if (s_req_o !== 1'b1 || s_we_o !== 1'b1 || s_be_o !== 4'b0011) begin
      errors++;
      $display("FAIL wr_ctrl s_req=%b s_we=%b s_be=%b expected 1 1 0011", s_req_o, s_we_o, s_be_o);
    end
    checks++;
    if (s_addr_o !== 32'h10 || s_wdata_o !== 32'hA5A5_1234 || m_gnt_o !== 3'b010) begin
      errors++;
      $display("FAIL wr_fields addr=%h wdata=%h gnt=%b expected 00000010 a5a51234 010", s_addr_o, s_wdata_o, m_gnt_o);
    end
    e.id = 1; e.data = 32'h10 ^ KEY;
    q.push_back(e);
    cyc();
    m_req_i = '1; m_we_i = '0;
    @(negedge clk_i);
    e = q.pop_front();
    checks++;
    if (m_rvalid_o !== N'(1 << e.id) || m_rdata_o !== e.data) begin
      errors++;
      $display("FAIL wr_resp rvalid=%b rdata=%h expected %b %h", m_rvalid_o, m_rdata_o, N'(1 << e.id), e.data);
    end
    checks++;
    if (m_gnt_o !== 3'b100) begin
      errors++;
      $display("FAIL wr_ptr_moved gnt=%b expected 100", m_gnt_o);
    end
    e.id = 2; e.data = 32'h300 ^ KEY;
    q.push_back(e);
    cyc();
    m_req_i = '0;
    @(negedge clk_i);
    e = q.pop_front();
    checks++;
    if (m_rvalid_o !== N'(1 << e.id) || m_rdata_o !== e.data) begin
      errors++;
      $display("FAIL wr_m2_resp rvalid=%b rdata=%h expected %b %h", m_rvalid_o, m_rdata_o, N'(1 << e.id), e.data);
    end
    cyc();
  endtask

  task automatic test_orphan_rvalid();
    ram_mode = 1'b0; man_rv = 1'b1; man_rd = 32'hDEAD_0000;
    @(negedge clk_i);
    checks++;
    if (m_rvalid_o !== '0 || outstanding_o !== 2'd0 || resp_err_o !== 1'b0) begin
      errors++;
      $display("FAIL orphan_route rvalid=%b outstanding=%0d err=%b expected 000 0 0", m_rvalid_o, outstanding_o, resp_err_o);
    end
    cyc();
    man_rv = 1'b0;
    @(negedge clk_i);
    checks++;
    if (resp_err_o !== 1'b1) begin
      errors++;
      $display("FAIL orphan_err err=%b expected 1", resp_err_o);
    end
    repeat (3) cyc();
    @(negedge clk_i);
    checks++;
    if (resp_err_o !== 1'b1 || outstanding_o !== 2'd0) begin
      errors++;
      $display("FAIL orphan_sticky err=%b outstanding=%0d expected 1 0", resp_err_o, outstanding_o);
    end
  endtask

  task automatic test_async_reset();
    #2;
    rst_ni = 1'b0;
    #1;
    checks++;
    if (resp_err_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_clears_err err=%b expected 0", resp_err_o);
    end
    cyc();
    rst_ni = 1'b1;
    ram_mode = 1'b0; man_rv = 1'b0; s_gnt_i = 1'b1; m_req_i = 3'b011;
    for (int g = 0; g < 2; g++) begin
      @(negedge clk_i);
      checks++;
      if (m_gnt_o !== N'(1 << g)) begin
        errors++;
        $display("FAIL ar_gnt%0d gnt=%b expected %b", g, m_gnt_o, N'(1 << g));
      end
      cyc();
    end
    m_req_i = '0;
    @(negedge clk_i);
    checks++;
    if (outstanding_o !== 2'd2) begin
      errors++;
      $display("FAIL ar_pending outstanding=%0d expected 2", outstanding_o);
    end
    #2;
    rst_ni = 1'b0;
    #1;
    checks++;
    if (outstanding_o !== 2'd0 || s_req_o !== 1'b0) begin
      errors++;
      $display("FAIL ar_async outstanding=%0d s_req=%b expected 0 0", outstanding_o, s_req_o);
    end
    q.delete();
    cyc();
    rst_ni = 1'b1;
    man_rv = 1'b1; man_rd = 32'h5151_5151;
    @(negedge clk_i);
    checks++;
    if (m_rvalid_o !== '0) begin
      errors++;
      $display("FAIL ar_stale_route rvalid=%b expected 000", m_rvalid_o);
    end
    cyc();
    man_rv = 1'b0;
    @(negedge clk_i);
    checks++;
    if (resp_err_o !== 1'b1) begin
      errors++;
      $display("FAIL ar_stale_err err=%b expected 1", resp_err_o);
    end
    cyc();
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_backpressure();
    test_single_write();
    test_orphan_rvalid();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
